airlock_sequencer: RTL and testbench
====================================

// Module: airlock_sequencer
// PURPOSE
//  Master controller for the airlock chamber. Arbitrates between the synchronized arrive/depart requests.
//  Sequences the granted trip: chamber evacuate/pressurize phases (timed), outer/inner door open phases (operator-confirmed).
//  Sits between the arrive/depart request logic and the door/pump drivers; owns the chamber-level flag.
// PARAMETERS
//  CNT_W        10  width of the phase timer
//  PRESS_CYCLES  7  clock cycles spent pressurizing (1..2^CNT_W-1)
//  EVAC_CYCLES   7  clock cycles spent evacuating (1..2^CNT_W-1)
// PORTS
//  clk           in   1  system clock, all state on rising edge
//  rst           in   1  asynchronous, active-low reset
//  arrive_req    in   1  level; vessel waiting outside, already synchronized
//  depart_req    in   1  level; vessel waiting inside, already synchronized
//  vessel_clear  in   1  level; vessel has passed through the open door
//  outer_open    out  1  open outer door
//  inner_open    out  1  open inner door
//  pressurizing  out  1  pump-up active
//  evacuating    out  1  pump-down active
//  chamber_press out  1  1 = chamber at inner level, 0 = at outer level
//  arrive_ack    out  1  1-cycle pulse: arrival granted
//  depart_ack    out  1  1-cycle pulse: departure granted
//  busy          out  1  high in every state except IDLE
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE, all outputs 0 except chamber_press=1, timer=0, last_dir=DEPART.
//  - States: IDLE, EVAC, PRESS, OPEN_OUTER, OPEN_INNER; dir register (ARRIVE/DEPART) latched at grant.
//  - IDLE: requests sampled each edge; if one grant -> ack pulse on the following cycle (registered, coincident
//    with first cycle of the next state). Next state:
//    ARRIVE: chamber_press=1 -> EVAC, else -> OPEN_OUTER.  DEPART: chamber_press=0 -> PRESS, else -> OPEN_INNER.
//  - EVAC: evacuating=1 for exactly EVAC_CYCLES cycles; on exit chamber_press<=0.
//    Then ARRIVE -> OPEN_OUTER; DEPART -> OPEN_OUTER.
//  - PRESS: pressurizing=1 for exactly PRESS_CYCLES cycles; on exit chamber_press<=1.
//    Then ARRIVE -> OPEN_INNER; DEPART -> OPEN_INNER.
//  - OPEN_OUTER: outer_open=1 until vessel_clear sampled high; then ARRIVE -> PRESS, DEPART -> IDLE.
//  - OPEN_INNER: inner_open=1 until vessel_clear sampled high; then ARRIVE -> IDLE, DEPART -> EVAC.
//  - vessel_clear sampled only in OPEN_* states; ignored elsewhere. Held high: each open phase still lasts >=1 cycle.
//  - Invariant: outer_open & inner_open never both 1; pump outputs mutually exclusive and 0 whenever a door is open.
//  - Requests while busy ignored (no queuing); a still-asserted request is re-arbitrated on return to IDLE.
//  - Timer: loaded with PHASE_CYCLES-1 on phase entry, decrements, phase exits on the cycle it reads 0; no wrap.
//  - Reset mid-sequence: immediate abort to IDLE, doors/pumps off, chamber_press=1 (safe inner level assumed).
// CONFIGURATION
//  ARB_ROUND_ROBIN_EN defined: simultaneous arrive_req & depart_req grant the direction opposite to last_dir;
//    last_dir updates at every grant.
//  ARB_ROUND_ROBIN_EN undefined: fixed priority, arrive always wins; last_dir register not built.
//  Single requests behave identically in both builds.
// STRUCTURE
//  airlock_pkg: state encoding constants (IDLE..OPEN_INNER, 3 bits), DIR_ARRIVE/DIR_DEPART, default cycle counts.
//  Sub-module phase_timer (CNT_W-bit loadable down-counter with zero flag) instanced once, shared by EVAC/PRESS.
//  Top: arbiter + FSM + registered outputs.
// TESTING
//  1 reset, arrive_req=1 -> arrive_ack pulse, evacuating=1 for 7 cycles, chamber_press->0, outer_open=1 until
//    vessel_clear, pressurizing 7 cycles, chamber_press->1, inner_open until vessel_clear, IDLE.
//  2 from chamber_press=1, depart_req=1 -> depart_ack, inner_open immediately (no PRESS), then EVAC 7 cycles,
//    outer_open, vessel_clear -> IDLE with chamber_press=0; next arrive skips EVAC.
//  3 both requests high from IDLE twice (RR build) -> grants ARRIVE then DEPART; fixed build -> ARRIVE both times.
//  4 depart_req pulsed during an arrival -> no depart_ack; held depart_req -> granted on first IDLE cycle.
//  5 rst=0 asserted mid-EVAC (cycle 3) -> all outputs 0 asynchronously, chamber_press=1, busy=0.
//  6 random run, PRESS_CYCLES=EVAC_CYCLES=1 -> assert door/pump exclusivity and 1-cycle pump phases every cycle.

Source files
------------

// File: rtl/airlock_pkg.sv
// Shared encodings and default timing for the airlock sequencer.
package airlock_pkg;
  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_EVAC       = 3'd1,
    S_PRESS      = 3'd2,
    S_OPEN_OUTER = 3'd3,
    S_OPEN_INNER = 3'd4
  } state_e;

  typedef enum logic {
    DIR_ARRIVE = 1'b0,
    DIR_DEPART = 1'b1
  } dir_e;

  localparam int DEF_CNT_W        = 10;
  localparam int DEF_PRESS_CYCLES = 7;
  localparam int DEF_EVAC_CYCLES  = 7;
endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter with zero flag; holds at zero instead of wrapping.
module phase_timer
  import airlock_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)                     r_cnt <= '0;
    else if (i_load)                r_cnt <= i_load_val;
    else if (i_dec && r_cnt != '0)  r_cnt <= r_cnt - 1'b1;
  end

  assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/airlock_sequencer.sv
// Airlock master: arbitrates arrive/depart, then walks pump and door phases.
// Define ARB_ROUND_ROBIN_EN to alternate grants on simultaneous requests.
module airlock_sequencer
  import airlock_pkg::*;
#(
  parameter int CNT_W        = DEF_CNT_W,
  parameter int PRESS_CYCLES = DEF_PRESS_CYCLES,
  parameter int EVAC_CYCLES  = DEF_EVAC_CYCLES
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_arrive_req,
  input  logic i_depart_req,
  input  logic i_vessel_clear,
  output logic o_outer_open,
  output logic o_inner_open,
  output logic o_pressurizing,
  output logic o_evacuating,
  output logic o_chamber_press,
  output logic o_arrive_ack,
  output logic o_depart_ack,
  output logic o_busy
);
  localparam logic [CNT_W-1:0] EVAC_LD  = CNT_W'(EVAC_CYCLES - 1);
  localparam logic [CNT_W-1:0] PRESS_LD = CNT_W'(PRESS_CYCLES - 1);

  state_e r_state;
  dir_e   r_dir;
  logic   r_outer, r_inner, r_prs, r_evac, r_cpress, r_aack, r_dack, r_busy;
  logic   w_grant, w_idle_go, w_evac_ld, w_press_ld, w_tmr_dec, w_tmr_zero;
  logic [CNT_W-1:0] w_tmr_val;
  dir_e   w_gdir;

`ifdef ARB_ROUND_ROBIN_EN
  dir_e   r_last_dir;
`endif

  always_comb begin
    w_grant = i_arrive_req | i_depart_req;
    w_gdir  = DIR_ARRIVE;
`ifdef ARB_ROUND_ROBIN_EN
    if (i_arrive_req && i_depart_req)
      w_gdir = (r_last_dir == DIR_ARRIVE) ? DIR_DEPART : DIR_ARRIVE;
    else if (i_depart_req)
      w_gdir = DIR_DEPART;
`else
    if (!i_arrive_req && i_depart_req)
      w_gdir = DIR_DEPART;
`endif
  end

  // Timer is loaded on the same edge the FSM enters a pump phase.
  assign w_idle_go  = (r_state == S_IDLE) && w_grant;
  assign w_evac_ld  = (w_idle_go && w_gdir == DIR_ARRIVE && r_cpress) ||
                      (r_state == S_OPEN_INNER && i_vessel_clear && r_dir == DIR_DEPART);
  assign w_press_ld = (w_idle_go && w_gdir == DIR_DEPART && !r_cpress) ||
                      (r_state == S_OPEN_OUTER && i_vessel_clear && r_dir == DIR_ARRIVE);
  assign w_tmr_val  = w_evac_ld ? EVAC_LD : PRESS_LD;
  assign w_tmr_dec  = (r_state == S_EVAC) || (r_state == S_PRESS);

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_evac_ld | w_press_ld),
    .i_load_val (w_tmr_val),
    .i_dec      (w_tmr_dec),
    .o_zero     (w_tmr_zero)
  );

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state  <= S_IDLE;
      r_dir    <= DIR_DEPART;
      r_outer  <= 1'b0;
      r_inner  <= 1'b0;
      r_prs    <= 1'b0;
      r_evac   <= 1'b0;
      r_cpress <= 1'b1;
      r_aack   <= 1'b0;
      r_dack   <= 1'b0;
      r_busy   <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      r_last_dir <= DIR_DEPART;
`endif
    end else begin
      r_aack <= 1'b0;
      r_dack <= 1'b0;
      case (r_state)
        S_IDLE: if (w_grant) begin
          r_dir  <= w_gdir;
          r_busy <= 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
          r_last_dir <= w_gdir;
`endif
          if (w_gdir == DIR_ARRIVE) begin
            r_aack <= 1'b1;
            if (r_cpress) begin r_state <= S_EVAC;       r_evac  <= 1'b1; end
            else          begin r_state <= S_OPEN_OUTER; r_outer <= 1'b1; end
          end else begin
            r_dack <= 1'b1;
            if (!r_cpress) begin r_state <= S_PRESS;      r_prs   <= 1'b1; end
            else           begin r_state <= S_OPEN_INNER; r_inner <= 1'b1; end
          end
        end
        S_EVAC: if (w_tmr_zero) begin
          r_evac   <= 1'b0;
          r_cpress <= 1'b0;
          r_outer  <= 1'b1;
          r_state  <= S_OPEN_OUTER;
        end
        S_PRESS: if (w_tmr_zero) begin
          r_prs    <= 1'b0;
          r_cpress <= 1'b1;
          r_inner  <= 1'b1;
          r_state  <= S_OPEN_INNER;
        end
        S_OPEN_OUTER: if (i_vessel_clear) begin
          r_outer <= 1'b0;
          if (r_dir == DIR_ARRIVE) begin r_state <= S_PRESS; r_prs  <= 1'b1; end
          else                     begin r_state <= S_IDLE;  r_busy <= 1'b0; end
        end
        S_OPEN_INNER: if (i_vessel_clear) begin
          r_inner <= 1'b0;
          if (r_dir == DIR_DEPART) begin r_state <= S_EVAC; r_evac <= 1'b1; end
          else                     begin r_state <= S_IDLE; r_busy <= 1'b0; end
        end
        default: begin
          r_state <= S_IDLE;
          r_outer <= 1'b0;
          r_inner <= 1'b0;
          r_prs   <= 1'b0;
          r_evac  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_outer_open    = r_outer;
  assign o_inner_open    = r_inner;
  assign o_pressurizing  = r_prs;
  assign o_evacuating    = r_evac;
  assign o_chamber_press = r_cpress;
  assign o_arrive_ack    = r_aack;
  assign o_depart_ack    = r_dack;
  assign o_busy          = r_busy;
endmodule

// File: tb/tb_airlock_sequencer.sv
// Directed bench for airlock_sequencer plus a 1-cycle-pump instance under random traffic.
module tb_airlock_sequencer;
  logic clk, rst;
  logic arr, dep, clr;
  logic arr1, dep1, clr1;
  logic o_outer, o_inner, o_prs, o_evac, o_cp, o_aack, o_dack, o_busy;
  logic q_outer, q_inner, q_prs, q_evac, q_cp, q_aack, q_dack, q_busy;
  logic [7:0] out;
  int n_chk = 0;
  int n_err = 0;

  // {outer, inner, pressurizing, evacuating, chamber_press, arrive_ack, depart_ack, busy}
  assign out = {o_outer, o_inner, o_prs, o_evac, o_cp, o_aack, o_dack, o_busy};

  airlock_sequencer dut (
    .i_clk(clk), .i_rst(rst), .i_arrive_req(arr), .i_depart_req(dep), .i_vessel_clear(clr),
    .o_outer_open(o_outer), .o_inner_open(o_inner), .o_pressurizing(o_prs), .o_evacuating(o_evac),
    .o_chamber_press(o_cp), .o_arrive_ack(o_aack), .o_depart_ack(o_dack), .o_busy(o_busy)
  );

  airlock_sequencer #(.CNT_W(10), .PRESS_CYCLES(1), .EVAC_CYCLES(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_arrive_req(arr1), .i_depart_req(dep1), .i_vessel_clear(clr1),
    .o_outer_open(q_outer), .o_inner_open(q_inner), .o_pressurizing(q_prs), .o_evacuating(q_evac),
    .o_chamber_press(q_cp), .o_arrive_ack(q_aack), .o_depart_ack(q_dack), .o_busy(q_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_run(input string tag, input logic [7:0] exp, input int n);
    for (int i = 0; i < n; i++) begin
      if (i > 0) step();
      chk(tag, {24'd0, out}, {24'd0, exp});
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    rst = 1'b1;
  endtask

  // Holds vessel_clear until the sequence returns to IDLE, bounded.
  task automatic finish_seq(input string tag);
    clr = 1'b1;
    for (int i = 0; i < 40 && o_busy; i++) step();
    chk(tag, {31'd0, o_busy}, 32'd0);
    clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic       p_prs, p_evac;
    logic [4:0] viol;
    int         pumps;
    rst = 1'b1; arr = 0; dep = 0; clr = 0; arr1 = 0; dep1 = 0; clr1 = 0;
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset", {24'd0, out}, 32'h08);
    rst = 1'b1;

    // 1: full arrival from pressurized chamber
    arr = 1; step(); arr = 0;
    chk("t1_ack", {24'd0, out}, 32'h1D);
    step(); chk_run("t1_evac", 8'b0001_1001, 6);
    step(); chk("t1_outer", {24'd0, out}, 32'h81);
    step(); chk("t1_outer_hold", {24'd0, out}, 32'h81);
    clr = 1; step(); clr = 0;
    chk_run("t1_press", 8'b0010_0001, 7);
    step(); chk("t1_inner", {24'd0, out}, 32'h49);
    clr = 1; step(); clr = 0;
    chk("t1_idle", {24'd0, out}, 32'h08);

    // 2: departure skips PRESS; held clear gives 1-cycle outer phase
    dep = 1; step(); dep = 0;
    chk("t2_ack", {24'd0, out}, 32'h4B);
    step(); chk("t2_inner", {24'd0, out}, 32'h49);
    clr = 1; step();
    chk_run("t2_evac", 8'b0001_1001, 7);
    step(); chk("t2_outer", {24'd0, out}, 32'h81);
    step(); clr = 0;
    chk("t2_idle", {24'd0, out}, 32'h00);
    arr = 1; step(); arr = 0;
    chk("t2_skip_evac", {24'd0, out}, 32'h85);
    clr = 1; step(); clr = 0;
    chk_run("t2_press", 8'b0010_0001, 7);
    step(); chk("t2_inner2", {24'd0, out}, 32'h49);
    clr = 1; step(); clr = 0;
    chk("t2_idle2", {24'd0, out}, 32'h08);

    // 3: simultaneous requests
    do_reset();
    arr = 1; dep = 1; step(); arr = 0; dep = 0;
    chk("t3_grant1", {24'd0, out}, 32'h1D);
    finish_seq("t3_done1");
    arr = 1; dep = 1; step(); arr = 0; dep = 0;
`ifdef ARB_ROUND_ROBIN_EN
    chk("t3_grant2", {24'd0, out}, 32'h4B);
`else
    chk("t3_grant2", {24'd0, out}, 32'h1D);
`endif
    finish_seq("t3_done2");

    // 4: requests while busy are dropped; a held one is granted at IDLE
    arr = 1; step(); arr = 0;
    chk("t4_aack", {31'd0, o_aack}, 32'd1);
    dep = 1; step();
    chk("t4_nodack1", {31'd0, o_dack}, 32'd0);
    step();
    chk("t4_nodack2", {31'd0, o_dack}, 32'd0);
    finish_seq("t4_idle");
    step();
    chk("t4_held_grant", {24'd0, out}, 32'h4B);
    dep = 0;
    finish_seq("t4_done");

    // 5: asynchronous reset in EVAC cycle 3
    do_reset();
    chk("t5_post_rst", {24'd0, out}, 32'h08);
    arr = 1; step(); arr = 0;
    step(); step();
    chk("t5_evac3", {24'd0, out}, 32'h19);
    #2 rst = 1'b0;
    #1 chk("t5_async", {24'd0, out}, 32'h08);
    step(); rst = 1'b1;
    step();
    chk("t5_idle", {24'd0, out}, 32'h08);

    // 6: random traffic on the 1-cycle-pump instance
    p_prs = 0; p_evac = 0; pumps = 0;
    for (int i = 0; i < 400; i++) begin
      arr1 = 1'($urandom_range(0, 1));
      dep1 = 1'($urandom_range(0, 1));
      clr1 = 1'($urandom_range(0, 1));
      step();
      viol = {q_outer & q_inner, q_prs & q_evac, (q_prs | q_evac) & (q_outer | q_inner),
              p_prs & q_prs, p_evac & q_evac};
      chk("t6_invariant", {27'd0, viol}, 32'd0);
      if (q_prs | q_evac) pumps++;
      p_prs = q_prs; p_evac = q_evac;
    end
    chk("t6_activity", {31'd0, (pumps > 0)}, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
